cpubus_seq_engine: RTL and testbench

Synthesizable, parametrised CPU-bus transaction sequencer for the tiny cache. It drives the cache's go/done CPU-bus handshake from a programmed command (base address, address count, repeat count, mode). It issues read, write or write-then-read-back sequences and self-checks read data against an address-derived pattern. It sits between a test or controller block and the cache CPU port, and replaces hand-sequenced read loops.

---
 rtl/cpubus_seq_engine.sv | 184 ++++++++++++++++++
 tb/tb_cpubus_seq_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpubus_seq_engine.sv
// rtl/cpubus_seq_engine.sv - CPU-bus read/write/read-back sequencer with pattern self-check
module cpubus_seq_engine #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          CNT_W   = 8,
  parameter int          TIMEOUT = 255,
  parameter int unsigned SEED    = 32'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_addr,
  input  logic [CNT_W-1:0]  repeat_cnt,
  output logic [ADDR_W-1:0] cpubus_address,
  output logic              transaction_req,
  output logic [DATA_W-1:0] cpubus_data_out,
  output logic              go,
  input  logic              done,
  input  logic [DATA_W-1:0] cpubus_data_in,
  output logic              busy,
  output logic              done_all,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] last_rd_data,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_FIN} state_t;

  localparam logic [1:0]        M_WRITE = 2'd1;
  localparam logic [1:0]        M_RAW   = 2'd2;
  localparam int                TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] SEED_W  = DATA_W'(SEED);
  localparam logic [CNT_W:0]    ONE_X   = (CNT_W+1)'(1);

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    num_q, rep_q, idx_q, rep_cnt_q;
  logic                wr_phase_q;
  logic [TO_W-1:0]     wait_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                req_q, go_q, busy_q, done_all_q, to_q;
  logic [DATA_W-1:0]   wdata_q, last_q;
  logic [CNT_W-1:0]    err_q;

  logic [CNT_W-1:0]    idx_d, rep_cnt_d;
  logic                wr_phase_d, seq_end_d, nxt_write_d;
  logic [ADDR_W-1:0]   nxt_addr_d;
  logic [CNT_W:0]      rep_next, idx_next;

  // Expected write pattern for an address; also the reference for RAW read-back.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + SEED_W;
  endfunction

  // Next operation chosen at the end of each transaction (consumed in GAP).
  always_comb begin
    idx_d       = idx_q;
    rep_cnt_d   = rep_cnt_q;
    wr_phase_d  = 1'b0;
    seq_end_d   = 1'b0;
    rep_next    = {1'b0, rep_cnt_q} + ONE_X;
    idx_next    = {1'b0, idx_q} + ONE_X;
    if (wr_phase_q) begin
      rep_cnt_d = '0;                       // RAW write done: reads of the same address follow
    end else if (rep_next < {1'b0, rep_q}) begin
      rep_cnt_d = rep_next[CNT_W-1:0];
    end else if (idx_next < {1'b0, num_q}) begin
      idx_d      = idx_next[CNT_W-1:0];
      rep_cnt_d  = '0;
      wr_phase_d = (mode_q == M_RAW);
    end else begin
      seq_end_d  = 1'b1;
    end
    nxt_write_d = (mode_q == M_WRITE) || ((mode_q == M_RAW) && wr_phase_d);
    nxt_addr_d  = base_q + ADDR_W'(idx_d);
  end

  // Sequencer FSM with all bus and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      num_q      <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      rep_cnt_q  <= '0;
      wr_phase_q <= 1'b0;
      wait_q     <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      wdata_q    <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_all_q <= 1'b0;
      to_q       <= 1'b0;
      err_q      <= '0;
      last_q     <= '0;
    end else begin
      done_all_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            base_q     <= base_addr;
            num_q      <= num_addr;
            rep_q      <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            idx_q      <= '0;
            rep_cnt_q  <= '0;
            wr_phase_q <= (mode == M_RAW);
            wait_q     <= '0;
            err_q      <= '0;
            to_q       <= 1'b0;
            busy_q     <= 1'b1;
            if (num_addr == '0) begin
              state_q    <= S_FIN;
              done_all_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              go_q    <= 1'b1;
              addr_q  <= base_addr;
              req_q   <= (mode == M_WRITE) || (mode == M_RAW);
              wdata_q <= pattern(base_addr);
            end
          end
        end
        S_REQ: begin
          if (done) begin
            go_q    <= 1'b0;
            state_q <= S_GAP;
            if (!req_q) begin
              last_q <= cpubus_data_in;
              if ((mode_q == M_RAW) && (cpubus_data_in != wdata_q) && (err_q != '1))
                err_q <= err_q + CNT_W'(1);
            end
          end else if (wait_q == TO_LAST) begin
            go_q       <= 1'b0;
            to_q       <= 1'b1;
            state_q    <= S_FIN;
            done_all_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        S_GAP: begin
          idx_q      <= idx_d;
          rep_cnt_q  <= rep_cnt_d;
          wr_phase_q <= wr_phase_d;
          wait_q     <= '0;
          if (seq_end_d) begin
            state_q    <= S_FIN;
            done_all_q <= 1'b1;
          end else begin
            state_q <= S_REQ;
            go_q    <= 1'b1;
            addr_q  <= nxt_addr_d;
            req_q   <= nxt_write_d;
            wdata_q <= pattern(nxt_addr_d);
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpubus_address  = addr_q;
  assign transaction_req = req_q;
  assign cpubus_data_out = wdata_q;
  assign go              = go_q;
  assign busy            = busy_q;
  assign done_all        = done_all_q;
  assign err_count       = err_q;
  assign last_rd_data    = last_q;
  assign timeout_flag    = to_q;

endmodule

// File: tb/tb_cpubus_seq_engine.sv
// tb/tb_cpubus_seq_engine.sv - scoreboard bench for cpubus_seq_engine with a cache model
module tb_cpubus_seq_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] base_addr = 8'h00, num_addr = 8'h00, repeat_cnt = 8'h00;
  logic       done = 1'b0;
  logic [7:0] cpubus_data_in = 8'h00;
  logic [7:0] cpubus_address, cpubus_data_out, err_count, last_rd_data;
  logic       transaction_req, go, busy, done_all, timeout_flag;

  cpubus_seq_engine #(.ADDR_W(8), .DATA_W(8), .CNT_W(8), .TIMEOUT(10), .SEED(32'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .num_addr(num_addr), .repeat_cnt(repeat_cnt), .cpubus_address(cpubus_address),
    .transaction_req(transaction_req), .cpubus_data_out(cpubus_data_out), .go(go),
    .done(done), .cpubus_data_in(cpubus_data_in), .busy(busy), .done_all(done_all),
    .err_count(err_count), .last_rd_data(last_rd_data), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic       w;
    logic [7:0] d;
  } txn_t;

  txn_t       sbq[$];
  txn_t       mt;
  logic [7:0] mem [256];
  int         lat = 1;
  int         wcnt = 0;
  bit         model_en = 1'b1;
  bit         corrupt_en = 1'b0;
  logic [7:0] corrupt_a = 8'h00;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a + 8'hA5;
  endfunction

  // Cache model: done after lat idle cycles of go; checks each issued op against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      done = 1'b0;
      wcnt = 0;
    end else if (done) begin
      done = 1'b0;
      wcnt = 0;
      check("gap_go_low", go, 0);
    end else if (go && model_en) begin
      if (wcnt >= lat) begin
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          mt = sbq.pop_front();
          check("addr", cpubus_address, mt.a);
          check("req", transaction_req, mt.w);
          if (mt.w) check("wdata", cpubus_data_out, mt.d);
        end
        if (transaction_req) mem[cpubus_address] = cpubus_data_out;
        else cpubus_data_in = (corrupt_en && cpubus_address == corrupt_a) ? 8'h00 : mem[cpubus_address];
        done = 1'b1;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic run_cmd(input string name, input logic [1:0] m, input logic [7:0] b,
                         input logic [7:0] n, input logic [7:0] r, input bit spur,
                         input bit exp_to, input bit chk_last, input logic [7:0] exp_last,
                         input logic [7:0] exp_err);
    int   nr, ntx, gocyc;
    bit   seen;
    txn_t t;
    logic [7:0] a;
    nr = (r == 0) ? 1 : int'(r);
    ntx = 0;
    sbq.delete();
    if (!exp_to) begin
      for (int k = 0; k < int'(n); k++) begin
        a = b + 8'(k);
        if (m == 2'd2) begin
          t.a = a; t.w = 1'b1; t.d = pat(a); sbq.push_back(t); ntx++;
        end
        for (int j = 0; j < nr; j++) begin
          t.a = a; t.w = (m == 2'd1); t.d = pat(a); sbq.push_back(t); ntx++;
        end
      end
    end
    @(negedge clk);
    mode = m; base_addr = b; num_addr = n; repeat_cnt = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_rise"}, busy, 1);
    check({name, "_to_cleared"}, timeout_flag, 0);
    gocyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (go) gocyc++;
      if (done_all) begin
        seen = 1'b1;
      end else begin
        if (spur && i == 4) begin
          start = 1'b1; mode = 2'd0; base_addr = 8'h77; num_addr = 8'd1; repeat_cnt = 8'd1;
        end
        if (spur && i == 5) start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({name, "_done_all_seen"}, seen, 1);
    check({name, "_go_cycles"}, gocyc, exp_to ? 10 : ntx * (lat + 1));
    @(negedge clk);
    check({name, "_done_all_pulse"}, done_all, 0);
    check({name, "_busy_fall"}, busy, 0);
    check({name, "_timeout_flag"}, timeout_flag, exp_to);
    check({name, "_err_count"}, err_count, exp_err);
    check({name, "_sb_drained"}, sbq.size(), 0);
    if (chk_last) check({name, "_last_rd"}, last_rd_data, exp_last);
  endtask

  initial begin
    bit seen_go;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    repeat (3) @(negedge clk);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_done_all", done_all, 0);
    check("rst_outputs", {cpubus_address, cpubus_data_out, last_rd_data, err_count}, 0);
    check("rst_req_to", {transaction_req, timeout_flag}, 0);
    rst = 1'b0;

    // Reset while a read request is outstanding.
    lat = 3;
    @(negedge clk);
    mode = 2'd0; base_addr = 8'h10; num_addr = 8'd4; repeat_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_go = 1'b0;
    for (int i = 0; i < 20 && !seen_go; i++) begin
      if (go) seen_go = 1'b1;
      else @(negedge clk);
    end
    check("midreq_go_seen", seen_go, 1);
    check("midreq_addr", cpubus_address, 8'h10);
    #2 rst = 1'b1;
    #1;
    check("midreq_go_drop", go, 0);
    check("midreq_busy", busy, 0);
    check("midreq_outputs", {cpubus_address, cpubus_data_out, last_rd_data, err_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    lat = 1;

    run_cmd("read8x2", 2'd0, 8'h00, 8'd8, 8'd2, 1'b0, 1'b0, 1'b1, 8'h3B, 8'd0);
    run_cmd("raw_wrap", 2'd2, 8'hFE, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 8'hA6, 8'd0);
    corrupt_en = 1'b1;
    run_cmd("raw_corrupt", 2'd2, 8'hFE, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 8'hA6, 8'd1);
    corrupt_en = 1'b0;
    model_en = 1'b0;
    run_cmd("timeout", 2'd0, 8'h30, 8'd2, 8'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
    model_en = 1'b1;
    run_cmd("num_zero", 2'd0, 8'h30, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
    run_cmd("rep_zero", 2'd0, 8'h40, 8'd2, 8'd0, 1'b0, 1'b0, 1'b1, 8'h7D, 8'd0);
    run_cmd("write_spur", 2'd1, 8'h20, 8'd3, 8'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0);
    lat = 0;
    run_cmd("mode3_read", 2'd3, 8'h50, 8'd2, 8'd1, 1'b0, 1'b0, 1'b1, 8'h6D, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
